// File: rtl/axi_usec_clock_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_usec_clock_reader_if
// Brief   : AXI4-Lite bus between the timestamp reader and the clock slave.
// Revision: 1.0 - initial release
// ============================================================================
interface axi_usec_clock_reader_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic [2:0]              AWPROT;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic [2:0]              ARPROT;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARVALID, ARPROT, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARVALID, ARPROT, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_usec_clock_reader.sv
`default_nettype none
// ============================================================================
// Module  : axi_usec_clock_reader
// Brief   : AXI4-Lite master reading a coherent 64-bit usec timestamp
//           (hi word first, which latches lo) and clearing the counter.
// Revision: 1.0 - initial release
// ============================================================================
module axi_usec_clock_reader #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 3,
  parameter int unsigned BASE_ADDR      = 0
) (
  input  wire logic               AXI_ACLK,
  input  wire logic               AXI_ARESET,
  input  wire logic               start_read,
  input  wire logic               start_clear,
  output logic                    busy,
  output logic [63:0]             timestamp,
  output logic                    timestamp_valid,
  output logic                    read_error,
  output logic                    clear_done,
  output logic                    write_error,
  axi_usec_clock_reader_if.master m_axi
);

  localparam logic [AXI_ADDR_WIDTH-1:0] c_addr_hi = AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] c_addr_lo = AXI_ADDR_WIDTH'(BASE_ADDR + 32'd4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_HI_A = 3'd1,
    S_RD_HI_R = 3'd2,
    S_RD_LO_A = 3'd3,
    S_RD_LO_R = 3'd4,
    S_WR_A    = 3'd5,
    S_WR_B    = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic                      pend_q, pend_d;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] hi_q, hi_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [63:0]               ts_q, ts_d;
  logic                      ts_valid_q, ts_valid_d;
  logic                      rerr_q, rerr_d;
  logic                      cdone_q, cdone_d;
  logic                      werr_q, werr_d;

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      hi_q       <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ts_q       <= '0;
      ts_valid_q <= 1'b0;
      rerr_q     <= 1'b0;
      cdone_q    <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      hi_q       <= hi_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      ts_q       <= ts_d;
      ts_valid_q <= ts_valid_d;
      rerr_q     <= rerr_d;
      cdone_q    <= cdone_d;
      werr_q     <= werr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    err_d      = err_q;
    hi_d       = hi_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    ts_d       = ts_q;
    ts_valid_d = 1'b0;
    rerr_d     = rerr_q;
    cdone_d    = 1'b0;
    werr_d     = werr_q;
    case (state_q)
      S_IDLE: begin
        if (start_clear) begin
          state_d   = S_WR_A;
          pend_d    = start_read;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (start_read) begin
          state_d = S_RD_HI_A;
          err_d   = 1'b0;
        end
      end
      S_RD_HI_A: if (m_axi.ARREADY) state_d = S_RD_HI_R;
      S_RD_HI_R: begin
        if (m_axi.RVALID) begin
          hi_d    = m_axi.RDATA;
          err_d   = err_q | (m_axi.RRESP != 2'b00);
          state_d = S_RD_LO_A;
        end
      end
      S_RD_LO_A: if (m_axi.ARREADY) state_d = S_RD_LO_R;
      S_RD_LO_R: begin
        if (m_axi.RVALID) begin
          ts_d       = {hi_q, m_axi.RDATA};
          ts_valid_d = 1'b1;
          rerr_d     = err_q | (m_axi.RRESP != 2'b00);
          state_d    = S_IDLE;
        end
      end
      S_WR_A: begin
        // AW and W retire independently; move on once both have gone.
        aw_done_d = aw_done_q | m_axi.AWREADY;
        w_done_d  = w_done_q | m_axi.WREADY;
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (m_axi.BVALID) begin
          cdone_d = 1'b1;
          werr_d  = (m_axi.BRESP != 2'b00);
          if (pend_q) begin
            pend_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_RD_HI_A;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_axi.ARVALID = (state_q == S_RD_HI_A) || (state_q == S_RD_LO_A);
  assign m_axi.ARADDR  = (state_q == S_RD_LO_A) ? c_addr_lo : c_addr_hi;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.RREADY  = (state_q == S_RD_HI_R) || (state_q == S_RD_LO_R);
  assign m_axi.AWVALID = (state_q == S_WR_A) && !aw_done_q;
  assign m_axi.AWADDR  = c_addr_hi;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.WVALID  = (state_q == S_WR_A) && !w_done_q;
  assign m_axi.WDATA   = '0;
  assign m_axi.WSTRB   = '1;
  assign m_axi.BREADY  = (state_q == S_WR_B);

  assign busy            = (state_q != S_IDLE);
  assign timestamp       = ts_q;
  assign timestamp_valid = ts_valid_q;
  assign read_error      = rerr_q;
  assign clear_done      = cdone_q;
  assign write_error     = werr_q;

endmodule
`default_nettype wire
